uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync3.sv | 26 ++
 rtl/uart_rx_cfg.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM state encoding,
// parity_mode encodings and the smallest bit period the receiver accepts.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } state_e;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   // Below four clocks per bit the mid-bit point and the vote window collapse.
   localparam int MIN_PRESCALE = 4;

endpackage

// File: rtl/uart_sync3.sv
// Three-flop synchronizer for the asynchronous serial line. Flops reset to 1
// so a reset never looks like a start bit.
module uart_sync3 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [2:0] sync_q;
   logic [2:0] sync_d;

   // Shift the raw line through the chain one stage per clock.
   always_comb begin
      sync_d = {sync_q[1:0], d};
   end

   // Chain register, idle-high after reset.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= 3'b111;
      else     sync_q <= sync_d;
   end

   assign q = sync_q[2];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/even/odd parity, one or two
// stop bits, runtime bit period, single-entry output register with overrun.
// Valid/ready: a word transfers on any cycle where m_valid && m_ready; m_valid
// stays high and m_data stays stable until that transfer happens.
// Build option: define UART_RX_MAJORITY_EN to take each sample as the 2-of-3
// vote of the synchronized line at timer values 2, 1 and 0.
module uart_rx_cfg #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rxd,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [1:0]            parity_mode,
   input  logic                  stop_bits,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  frame_err,
   output logic                  parity_err,
   output logic                  overrun_err,
   output logic [2:0]            state_dbg
);

   import uart_pkg::*;

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic                  rxd_s;
   logic                  sample_bit;
   logic                  tick;
   logic                  parity_en;
   logic                  fail_now;
   logic                  deliver;
   logic [PRESCALE_W-1:0] presc_eff;

   state_e                state_q, state_d;
   logic [PRESCALE_W-1:0] timer_q, timer_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [1:0]            pmode_q, pmode_d;
   logic                  stop2_q, stop2_d;
   logic                  stop_cnt_q, stop_cnt_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_fail_q, par_fail_d;
   logic                  frame_fail_q, frame_fail_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic                  m_valid_q, m_valid_d;
   logic                  frame_err_q, frame_err_d;
   logic                  parity_err_q, parity_err_d;
   logic                  overrun_q, overrun_d;

   uart_sync3 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rxd),
      .q   (rxd_s)
   );

`ifdef UART_RX_MAJORITY_EN
   logic vote2_q, vote2_d;
   logic vote1_q, vote1_d;

   // Capture the line two and one clocks before each sample point.
   always_comb begin
      vote2_d = (timer_q == PRESCALE_W'(2)) ? rxd_s : vote2_q;
      vote1_d = (timer_q == PRESCALE_W'(1)) ? rxd_s : vote1_q;
   end

   // Vote history registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         vote2_q <= 1'b1;
         vote1_q <= 1'b1;
      end else begin
         vote2_q <= vote2_d;
         vote1_q <= vote1_d;
      end
   end

   assign sample_bit = (vote2_q & vote1_q) | (vote2_q & rxd_s) | (vote1_q & rxd_s);
`else
   assign sample_bit = rxd_s;
`endif

   assign tick      = (timer_q == '0);
   assign parity_en = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
   assign presc_eff = (prescale < PRESCALE_W'(MIN_PRESCALE)) ? PRESCALE_W'(MIN_PRESCALE) : prescale;

   // Frame FSM, bit timer and output register next-state logic.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      presc_d      = presc_q;
      pmode_d      = pmode_q;
      stop2_d      = stop2_q;
      stop_cnt_d   = stop_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_fail_d   = par_fail_q;
      frame_fail_d = frame_fail_q;
      m_data_d     = m_data_q;
      m_valid_d    = m_valid_q;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      overrun_d    = 1'b0;
      deliver      = 1'b0;
      fail_now     = frame_fail_q | ~sample_bit;

      // The timer free-runs through every in-frame state, reloading at each sample point.
      if (state_q != IDLE && state_q != WAIT_HIGH) begin
         timer_d = tick ? (presc_q - PRESCALE_W'(1)) : (timer_q - PRESCALE_W'(1));
      end

      case (state_q)
         IDLE: begin
            if (!rxd_s) begin
               presc_d      = presc_eff;
               pmode_d      = parity_mode;
               stop2_d      = stop_bits;
               timer_d      = (presc_eff >> 1) - PRESCALE_W'(1);
               par_fail_d   = 1'b0;
               frame_fail_d = 1'b0;
               bit_cnt_d    = '0;
               stop_cnt_d   = 1'b0;
               state_d      = START;
            end
         end
         START: begin
            if (tick) state_d = sample_bit ? IDLE : DATA;
         end
         DATA: begin
            if (tick) begin
               shift_d = {sample_bit, shift_q[DATA_WIDTH-1:1]};
               if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                  state_d    = parity_en ? PARITY : STOP;
                  stop_cnt_d = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         PARITY: begin
            if (tick) begin
               if (sample_bit != ((^shift_q) ^ (pmode_q == PAR_ODD))) par_fail_d = 1'b1;
               state_d = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               if (stop2_q && !stop_cnt_q) begin
                  stop_cnt_d   = 1'b1;
                  frame_fail_d = fail_now;
               end else if (fail_now) begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_HIGH;
               end else if (par_fail_q) begin
                  parity_err_d = 1'b1;
                  state_d      = IDLE;
               end else begin
                  deliver = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WAIT_HIGH: begin
            if (rxd_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A delivery into a full, unconsumed register is dropped and flagged.
      if (deliver) begin
         if (!m_valid_q || m_ready) begin
            m_data_d  = shift_q;
            m_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         presc_q      <= '0;
         pmode_q      <= PAR_NONE;
         stop2_q      <= 1'b0;
         stop_cnt_q   <= 1'b0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_fail_q   <= 1'b0;
         frame_fail_q <= 1'b0;
         m_data_q     <= '0;
         m_valid_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         presc_q      <= presc_d;
         pmode_q      <= pmode_d;
         stop2_q      <= stop2_d;
         stop_cnt_q   <= stop_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_fail_q   <= par_fail_d;
         frame_fail_q <= frame_fail_d;
         m_data_q     <= m_data_d;
         m_valid_q    <= m_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign m_data      = m_data_q;
   assign m_valid     = m_valid_q;
   assign busy        = (state_q != IDLE);
   assign frame_err   = frame_err_q;
   assign parity_err  = parity_err_q;
   assign overrun_err = overrun_q;
   assign state_dbg   = state_q;

endmodule
